// File: rtl/br_fifo_shared_read_arb_wrr_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | br_fifo_shared_read_arb_wrr_if                                        |
// | Request/grant bundle between per-FIFO read requesters and one read    |
// | port of the shared multi-FIFO pop controller.                         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface br_fifo_shared_read_arb_wrr_if #(
  parameter int NumFifos  = 2,
  parameter int DataWidth = 1
);
  logic [NumFifos-1:0]           push_valid;
  logic [NumFifos-1:0]           push_ready;
  logic [NumFifos*DataWidth-1:0] push_data;
  logic                          pop_valid;
  logic                          pop_ready;
  logic [DataWidth-1:0]          pop_data;

  // Requesters and the read-address consumer
  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  // The arbiter
  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );
endinterface
`default_nettype wire

// File: rtl/br_fifo_shared_read_arb_wrr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | br_fifo_shared_read_arb_wrr                                           |
// | Weighted round-robin arbiter for one read port of the shared          |
// | multi-FIFO pop controller. Each burst owner keeps the grant for       |
// | w_eff grants before rotation; stalled grants are held stable.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module br_fifo_shared_read_arb_wrr #(
  parameter int NumFifos           = 2,
  parameter int DataWidth          = 1,
  parameter int WeightWidth        = 4,
  parameter int RegisterPopOutputs = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NumFifos*WeightWidth-1:0] cfg_weight,
  br_fifo_shared_read_arb_wrr_if.slave    bus
);
  localparam int              PTR_W      = $clog2(NumFifos);
  localparam logic [PTR_W-1:0] c_ptr_init = PTR_W'(NumFifos - 1);

  if (NumFifos < 2) begin : g_bad_num_fifos
    $error("NumFifos must be >= 2");
  end

  logic [PTR_W-1:0]       r_ptr;
  logic [WeightWidth-1:0] r_credit;
  logic                   r_hold;
  logic [PTR_W-1:0]       r_held_idx;

  logic                   w_search_valid;
  logic [PTR_W-1:0]       w_search_idx;
  logic                   w_grant_valid;
  logic [PTR_W-1:0]       w_grant_idx;
  logic [DataWidth-1:0]   w_grant_data;
  logic [WeightWidth-1:0] w_cfg;
  logic [WeightWidth-1:0] w_eff;
  logic                   w_load;
  logic                   w_accept;

  // Rotating search ptr+1, ptr+2, ... with ptr itself checked last;
  // iterating from the far end lets the nearest hit win.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    w_search_valid = 1'b0;
    w_search_idx   = '0;
    v_idx          = '0;
    for (int k = NumFifos; k >= 1; k--) begin
      v_idx = PTR_W'((int'(r_ptr) + k) % NumFifos);
      if (bus.push_valid[v_idx]) begin
        w_search_valid = 1'b1;
        w_search_idx   = v_idx;
      end
    end
  end

  // Grant priority: stalled grant, then current burst owner, then rotation
  always_comb begin
    w_grant_valid = w_search_valid;
    w_grant_idx   = w_search_idx;
    if (r_hold && bus.push_valid[r_held_idx]) begin
      w_grant_valid = 1'b1;
      w_grant_idx   = r_held_idx;
    end else if (bus.push_valid[r_ptr] && (r_credit != '0)) begin
      w_grant_valid = 1'b1;
      w_grant_idx   = r_ptr;
    end
  end

  assign w_grant_data = bus.push_data[int'(w_grant_idx)*DataWidth +: DataWidth];
  assign w_cfg        = cfg_weight[int'(w_grant_idx)*WeightWidth +: WeightWidth];
  assign w_eff        = (w_cfg == '0) ? WeightWidth'(1) : w_cfg;
  assign w_accept     = rst_n & w_load & w_grant_valid;

  // One-hot grant back to the winning requester
  always_comb begin
    bus.push_ready = '0;
    if (w_accept) begin
      bus.push_ready[w_grant_idx] = 1'b1;
    end
  end

  if (RegisterPopOutputs != 0) begin : g_reg_out
    logic                 r_pop_valid;
    logic [DataWidth-1:0] r_pop_data;

    assign w_load = !r_pop_valid || bus.pop_ready;

    // Single-entry output slot, refilled whenever empty or drained
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pop_valid <= 1'b0;
        r_pop_data  <= '0;
      end else if (w_load) begin
        r_pop_valid <= w_grant_valid;
        if (w_grant_valid) begin
          r_pop_data <= w_grant_data;
        end
      end
    end

    assign bus.pop_valid = r_pop_valid;
    assign bus.pop_data  = r_pop_data;

    a_pop_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.pop_valid && !bus.pop_ready) |=> (bus.pop_valid && $stable(bus.pop_data)));
  end else begin : g_comb_out
    // Outputs forced low while reset is asserted so they drop immediately
    assign w_load        = bus.pop_ready;
    assign bus.pop_valid = rst_n & w_grant_valid;
    assign bus.pop_data  = rst_n ? w_grant_data : '0;
  end

  // Burst owner / credit bookkeeping, plus stall capture in the bypass mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= c_ptr_init;
      r_credit   <= '0;
      r_hold     <= 1'b0;
      r_held_idx <= '0;
    end else if (w_accept) begin
      r_hold <= 1'b0;
      if ((w_grant_idx == r_ptr) && (r_credit != '0)) begin
        r_credit <= r_credit - WeightWidth'(1);
      end else begin
        r_ptr    <= w_grant_idx;
        r_credit <= w_eff - WeightWidth'(1);
      end
    end else if ((RegisterPopOutputs == 0) && w_grant_valid && !bus.pop_ready) begin
      r_hold     <= 1'b1;
      r_held_idx <= w_grant_idx;
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.push_ready));
  a_ready_has_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.push_ready & ~bus.push_valid) == '0);
  a_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({bus.pop_valid, bus.push_ready}));
endmodule
`default_nettype wire

// File: tb/tb_br_fifo_shared_read_arb_wrr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_br_fifo_shared_read_arb_wrr                                        |
// | Bench for the WRR read arbiter: one bypass-output and one registered- |
// | output instance share requests; a reference model feeds scoreboards.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_br_fifo_shared_read_arb_wrr;
  localparam int NF = 3;
  localparam int DW = 8;
  localparam int WW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NF*WW-1:0]  cfg;
  int                wt[NF];
  logic [NF-1:0]     pv;
  logic              pr0, pr1;
  logic [5:0]        cnt0[NF];
  logic [5:0]        cnt1[NF];
  logic [NF-1:0]     inc0, inc1;

  int   n_vec = 0;
  int   n_err = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  int   m0_ptr, m0_credit, m0_held;
  bit   m0_hold;
  int   m1_ptr, m1_credit;
  bit   m1_valid;

  int            obs_g0, obs_g1;
  logic [DW-1:0] obs_d0;
  logic          obs_pv1;
  int            seq2[6] = '{0, 0, 0, 1, 2, 2};

  br_fifo_shared_read_arb_wrr_if #(.NumFifos(NF), .DataWidth(DW)) bus0 ();
  br_fifo_shared_read_arb_wrr_if #(.NumFifos(NF), .DataWidth(DW)) bus1 ();

  assign bus0.push_valid = pv;
  assign bus1.push_valid = pv;
  assign bus0.pop_ready  = pr0;
  assign bus1.pop_ready  = pr1;

  always_comb begin
    cfg            = '0;
    bus0.push_data = '0;
    bus1.push_data = '0;
    for (int i = 0; i < NF; i++) begin
      cfg[i*WW +: WW]            = WW'(wt[i]);
      bus0.push_data[i*DW +: DW] = {2'(i), cnt0[i]};
      bus1.push_data[i*DW +: DW] = {2'(i), cnt1[i]};
    end
  end

  br_fifo_shared_read_arb_wrr #(
    .NumFifos(NF), .DataWidth(DW), .WeightWidth(WW), .RegisterPopOutputs(0)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .cfg_weight(cfg), .bus(bus0));

  br_fifo_shared_read_arb_wrr #(
    .NumFifos(NF), .DataWidth(DW), .WeightWidth(WW), .RegisterPopOutputs(1)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .cfg_weight(cfg), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int weff(input int i);
    return (wt[i] == 0) ? 1 : wt[i];
  endfunction

  function automatic int dec(input logic [NF-1:0] v);
    int r = -1;
    for (int i = NF - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Reference grant choice written straight from the selection rules
  task automatic pick(input logic [NF-1:0] v, input int ptr, input int credit,
                      input bit hold, input int held, output bit f, output int g);
    f = 1'b0;
    g = 0;
    if (hold && v[held]) begin
      f = 1'b1; g = held;
    end else if (v[ptr] && credit != 0) begin
      f = 1'b1; g = ptr;
    end else begin
      for (int k = 1; k <= NF; k++) begin
        int idx;
        idx = (ptr + k) % NF;
        if (!f && v[idx]) begin
          f = 1'b1; g = idx;
        end
      end
    end
  endtask

  task automatic upd(inout int ptr, inout int credit, input int g);
    if (g == ptr && credit != 0) credit = credit - 1;
    else begin
      ptr    = g;
      credit = weff(g) - 1;
    end
  endtask

  // One clock: check both instances at the falling edge, commit at the rising edge
  task automatic cycle();
    bit            f;
    int            g;
    bit            load;
    logic [NF-1:0] ex;
    logic [DW-1:0] d;
    @(negedge clk);
    inc0    = '0;
    inc1    = '0;
    obs_g0  = dec(bus0.push_ready);
    obs_g1  = dec(bus1.push_ready);
    obs_d0  = bus0.pop_data;
    obs_pv1 = bus1.pop_valid;

    pick(pv, m0_ptr, m0_credit, m0_hold, m0_held, f, g);
    ex = (f && pr0) ? NF'(1 << g) : '0;
    check("push_ready0", 32'(bus0.push_ready), 32'(ex));
    check("pop_valid0", 32'(bus0.pop_valid), 32'(f));
    if (f) q0.push_back({g[1:0], cnt0[g]});
    if (bus0.pop_valid) begin
      if (q0.size() == 0) check("q0_empty", 32'(q0.size()), 1);
      else begin
        d = q0.pop_front();
        check("pop_data0", 32'(bus0.pop_data), 32'(d));
      end
    end
    if (f && pr0) begin
      inc0[g] = 1'b1;
      m0_hold = 1'b0;
      upd(m0_ptr, m0_credit, g);
    end else if (f) begin
      m0_hold = 1'b1;
      m0_held = g;
    end

    load = !m1_valid || pr1;
    pick(pv, m1_ptr, m1_credit, 1'b0, 0, f, g);
    ex = (f && load) ? NF'(1 << g) : '0;
    check("push_ready1", 32'(bus1.push_ready), 32'(ex));
    check("pop_valid1", 32'(bus1.pop_valid), 32'(m1_valid));
    if (bus1.pop_valid) begin
      if (q1.size() == 0) check("q1_empty", 32'(q1.size()), 1);
      else begin
        check("pop_data1", 32'(bus1.pop_data), 32'(q1[0]));
        if (pr1) void'(q1.pop_front());
      end
    end
    if (f && load) begin
      q1.push_back({g[1:0], cnt1[g]});
      inc1[g] = 1'b1;
      upd(m1_ptr, m1_credit, g);
    end
    if (load) m1_valid = f;

    @(posedge clk);
    #1;
    for (int i = 0; i < NF; i++) begin
      if (inc0[i]) cnt0[i] = cnt0[i] + 6'd1;
      if (inc1[i]) cnt1[i] = cnt1[i] + 6'd1;
    end
  endtask

  // Asynchronous reset pulse applied between clock edges
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pop_valid0", 32'(bus0.pop_valid), 0);
    check("rst_pop_valid1", 32'(bus1.pop_valid), 0);
    check("rst_push_ready0", 32'(bus0.push_ready), 0);
    check("rst_push_ready1", 32'(bus1.push_ready), 0);
    check("rst_pop_data0", 32'(bus0.pop_data), 0);
    repeat (2) @(posedge clk);
    #1;
    m0_ptr = NF - 1; m0_credit = 0; m0_hold = 1'b0; m0_held = 0;
    m1_ptr = NF - 1; m1_credit = 0; m1_valid = 1'b0;
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int a1;
    rst_n = 1'b1;
    pv    = '1;
    pr0   = 1'b1;
    pr1   = 1'b1;
    wt    = '{1, 1, 1};
    for (int i = 0; i < NF; i++) begin
      cnt0[i] = '0;
      cnt1[i] = '0;
    end
    #2;
    do_reset();

    // Equal weights: plain round robin starting at FIFO 0
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr_grant", obs_g0, k % 3);
    end

    // Weights {3,1,2}, everyone busy
    wt = '{3, 1, 2};
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle();
      check("wrr_grant", obs_g0, seq2[k % 6]);
    end

    // Lone requester keeps winning through the wrap search
    wt = '{2, 2, 1};
    pv = 3'b010;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("solo_grant0", obs_g0, 1);
      check("solo_grant1", obs_g1, 1);
    end

    // Stalled grant to FIFO 2 must survive a competing FIFO 0 request
    pv  = 3'b100;
    pr0 = 1'b0;
    cycle();
    pv = 3'b101;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("hold_id", 32'(obs_d0[7:6]), 2);
      check("hold_ready", obs_g0, -1);
    end
    pr0 = 1'b1;
    cycle();
    check("hold_release", obs_g0, 2);

    // Registered outputs with a toggling consumer
    wt = '{3, 1, 2};
    pv = '1;
    do_reset();
    a1 = 0;
    for (int k = 0; k < 16; k++) begin
      pr1 = (k % 2 == 0);
      cycle();
      if (k >= 1) check("reg_valid", 32'(obs_pv1), 1);
      if (obs_g1 >= 0) begin
        check("reg_order", obs_g1, seq2[a1 % 6]);
        a1++;
      end
    end
    pr1 = 1'b1;

    // Reset in the middle of FIFO 0's burst
    do_reset();
    cycle();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("post_rst_grant", obs_g0, seq2[k]);
    end

    // Random traffic, zero weight and a mid-run weight change
    wt = '{0, 2, 3};
    for (int k = 0; k < 300; k++) begin
      if (k == 150) wt = '{2, 0, 1};
      pv  = NF'($urandom);
      pr0 = 1'($urandom);
      pr1 = 1'($urandom_range(0, 3) != 0);
      cycle();
    end

    // Drain and confirm nothing is left over
    pv  = '0;
    pr0 = 1'b1;
    pr1 = 1'b1;
    repeat (3) cycle();
    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/br_fifo_shared_read_arb_wrr.md
Name: br_fifo_shared_read_arb_wrr

Overview:
- Weighted round-robin arbiter for one read port of the shared multi-FIFO pop controller.
- Plugs into the controller's external arbiter interface: one instance per read port.
- Its push side takes the per-FIFO read requests; its pop side drives that port's read-address grant.
- Per-FIFO weights set burst length, so hot FIFOs can get more of the read bandwidth while every FIFO remains starvation-free.

Parameters:
- NumFifos, 2, number of requesters; must be >=2.
- DataWidth, 1, width of request payload ({fifo id, address}); must be >=1.
- WeightWidth, 4, width of each per-FIFO weight; must be >=1.
- RegisterPopOutputs, 0, if 1, pop_valid/pop_data come from a 1-entry pipeline register.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_weight  in  NumFifos*WeightWidth  grants per burst for each FIFO; 0 is treated as 1; quasi-static.
- push_valid  in  NumFifos  per-FIFO request valid.
- push_ready  out  NumFifos  per-FIFO grant/accept.
- push_data  in  NumFifos*DataWidth  per-FIFO request payload.
- pop_valid  out  1  arbitrated request valid.
- pop_ready  in  1  downstream accept.
- pop_data  out  DataWidth  payload of the granted FIFO.

Behaviour:
- State:
  - ptr: $clog2(NumFifos) bits, index of the current burst owner.
  - credit: WeightWidth bits, grants remaining in the current burst.
  - hold: 1 bit, set when a grant was stalled.
  - held_idx: index of the stalled grant.
- Reset (async, rst_n low):
  - ptr=NumFifos-1, credit=0, hold=0.
  - pop_valid=0, pop_data=0, push_ready=0.
  - Effect: FIFO 0 has first priority after reset.
- Weight w_eff[i] = (cfg_weight[i]==0) ? 1 : cfg_weight[i].
- Grant selection (combinational, every cycle):
  - If hold and push_valid[held_idx]: g=held_idx.
  - Else if push_valid[ptr] and credit!=0: g=ptr.
  - Else g = first i with push_valid[i], searching ptr+1, ptr+2, … wrapping, with ptr checked last.
  - No valid requester: no grant.
- Accept event: grant exists and the downstream slot accepts.
  - On accept of g==ptr with credit!=0: credit <= credit-1.
  - On accept of any other g: ptr <= g, credit <= w_eff[g]-1.
  - On accept, state updates at the next edge; hold <= 0.
- RegisterPopOutputs=0:
  - pop_valid = |push_valid; pop_data = push_data[g].
  - push_ready[i] = pop_ready && (i==g).
  - Accept = pop_valid && pop_ready; zero latency.
  - pop_valid && !pop_ready: hold <= 1, held_idx <= g.
  - If the held requester withdraws valid (allowed when upstream has no staging buffer), hold is ignored and normal selection resumes; hold clears on the next accept.
- RegisterPopOutputs=1:
  - Output register slot: load = !pop_valid || pop_ready.
  - push_ready[i] = load && (i==g).
  - Accept = load && grant; the register captures push_data[g] and pop_valid <= 1.
  - If load and no grant: pop_valid <= 0.
  - Latency: 1 cycle; full throughput of 1 grant/cycle.
  - pop_valid/pop_data stay stable while !pop_ready. hold is unused (tie 0).
- Invariants:
  - At most one push_ready bit set per cycle (onehot0).
  - push_ready[i] implies push_valid[i].
  - A requester continuously valid is granted within sum over j!=i of w_eff[j] accepts.
- Boundary conditions:
  - credit reaching 0 forces rotation even if ptr is the only other valid source.
  - If ptr is the only valid requester, it is re-granted via the wrap search and credit reloads.
  - NumFifos not a power of 2: the ptr+k index wraps modulo NumFifos.
  - A cfg_weight change mid-burst takes effect on the next burst reload; the current credit is unaffected.
  - Reset mid-burst clears all state asynchronously; pop_valid drops immediately.
- Assertions:
  - push_ready onehot0.
  - pop_valid stable while !pop_ready when RegisterPopOutputs=1.
  - No unknowns on pop_valid/push_ready after reset.

Test Plan:
- NumFifos=3, weights {1,1,1}, all valid, pop_ready=1 → grants cycle 0,1,2,0,1,2 from the first cycle after reset.
- Weights {3,1,2}, all valid continuously → grant sequence 0,0,0,1,2,2,0,0,0,… repeating; 6 accepts per period.
- Weights {2,2}, only FIFO 1 valid → grants 1 every cycle; credit reloads each time the wrap search returns to ptr.
- RegisterPopOutputs=0, FIFO 2 granted, pop_ready=0 for 4 cycles while FIFO 0 also valid → pop_data stays FIFO 2's payload, push_ready all 0; on pop_ready=1, FIFO 2 is accepted.
- RegisterPopOutputs=1, all valid, pop_ready toggling 1,0,1,0 → pop_valid high from cycle 1, data stable during stalls, no lost or duplicated grants; scoreboard order matches the WRR sequence.
- Assert rst_n low mid-burst (credit=2) → pop_valid=0 asynchronously; after release, the first grant goes to FIFO 0 with full weight.
